// File: rtl/ysyx_22050019_axi_pkg.sv
// ysyx_22050019_axi_pkg: AXI read-channel encodings and the arbiter's state
// and grant enums, shared by the read arbiter and its pick sub-module.
package ysyx_22050019_axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [2:0] SIZE_8B     = 3'b011;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_AR   = 2'b01,
    S_R    = 2'b10
  } arb_state_e;

  typedef enum logic {
    GNT_IC = 1'b0,
    GNT_DC = 1'b1
  } grant_e;

endpackage

// File: rtl/ysyx_22050019_arb2.sv
// ysyx_22050019_arb2: two-way pick between the icache and dcache requests.
// With YSYX_22050019_ARB_ROUND_ROBIN_EN defined a tie goes to the requester
// that did not win the last accepted AR; otherwise dcache always wins a tie.
module ysyx_22050019_arb2
  import ysyx_22050019_axi_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   ic_req,
  input  logic   dc_req,
  input  logic   win_accept,  // the current grant's AR was taken by the bus
  input  grant_e win_grant,   // grant that was taken
  output grant_e pick
);

`ifdef YSYX_22050019_ARB_ROUND_ROBIN_EN
  grant_e last_grant_r;

  // Remember which requester won the most recently accepted AR
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_r <= GNT_IC;
    end else if (win_accept) begin
      last_grant_r <= win_grant;
    end else begin
      last_grant_r <= last_grant_r;
    end
  end

  // On a tie favour the requester that was not served last
  always_comb begin
    pick = GNT_IC;
    if (ic_req && dc_req) begin
      if (last_grant_r == GNT_IC) begin
        pick = GNT_DC;
      end else begin
        pick = GNT_IC;
      end
    end else if (dc_req) begin
      pick = GNT_DC;
    end else begin
      pick = GNT_IC;
    end
  end
`else
  logic unused_rr_s;
  assign unused_rr_s = ^{clk, rst, ic_req, win_accept, logic'(win_grant)};

  // Fixed priority: dcache wins whenever it is requesting
  always_comb begin
    pick = GNT_IC;
    if (dc_req) begin
      pick = GNT_DC;
    end else begin
      pick = GNT_IC;
    end
  end
`endif

endmodule

// File: rtl/ysyx_22050019_axi_rd_arbiter.sv
// ysyx_22050019_axi_rd_arbiter: shares one AXI4 AR/R channel pair between the
// icache and dcache refill ports. One transaction at a time; the grant is held
// from arbitration until the r_last beat is accepted. Tie-break policy is set
// by YSYX_22050019_ARB_ROUND_ROBIN_EN (undefined: dcache has fixed priority).
module ysyx_22050019_axi_rd_arbiter
  import ysyx_22050019_axi_pkg::*;
#(
  parameter int          ADDR_WIDTH = 32,
  parameter int          DATA_WIDTH = 64,
  parameter int          LEN_WIDTH  = 8,
  parameter int          ID_WIDTH   = 4,
  parameter int unsigned IC_ID      = 0,
  parameter int unsigned DC_ID      = 1
)(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ic_ar_valid_i,
  output logic                  ic_ar_ready_o,
  input  logic [ADDR_WIDTH-1:0] ic_ar_addr_i,
  input  logic [LEN_WIDTH-1:0]  ic_ar_len_i,
  output logic                  ic_r_valid_o,
  input  logic                  ic_r_ready_i,
  output logic [1:0]            ic_r_resp_o,
  output logic                  ic_r_last_o,
  output logic [DATA_WIDTH-1:0] ic_r_data_o,
  input  logic                  dc_ar_valid_i,
  output logic                  dc_ar_ready_o,
  input  logic [ADDR_WIDTH-1:0] dc_ar_addr_i,
  input  logic [LEN_WIDTH-1:0]  dc_ar_len_i,
  output logic                  dc_r_valid_o,
  input  logic                  dc_r_ready_i,
  output logic [1:0]            dc_r_resp_o,
  output logic                  dc_r_last_o,
  output logic [DATA_WIDTH-1:0] dc_r_data_o,
  output logic                  m_ar_valid_o,
  input  logic                  m_ar_ready_i,
  output logic [ADDR_WIDTH-1:0] m_ar_addr_o,
  output logic [LEN_WIDTH-1:0]  m_ar_len_o,
  output logic [2:0]            m_ar_size_o,
  output logic [1:0]            m_ar_burst_o,
  output logic [ID_WIDTH-1:0]   m_ar_id_o,
  input  logic                  m_r_valid_i,
  output logic                  m_r_ready_o,
  input  logic [1:0]            m_r_resp_i,
  input  logic                  m_r_last_i,
  input  logic [DATA_WIDTH-1:0] m_r_data_i
);

  localparam logic [ID_WIDTH-1:0] IC_ID_C = ID_WIDTH'(IC_ID);
  localparam logic [ID_WIDTH-1:0] DC_ID_C = ID_WIDTH'(DC_ID);

  arb_state_e            state_r, state_s;
  grant_e                grant_r, grant_s, pick_s;
  logic [ADDR_WIDTH-1:0] addr_r, addr_s;
  logic [LEN_WIDTH-1:0]  len_r, len_s;
  logic [ID_WIDTH-1:0]   id_r, id_s;
  logic                  ar_fire_s;
  logic                  r_done_s;

  ysyx_22050019_arb2 u_arb2 (
    .clk        (clk),
    .rst        (rst),
    .ic_req     (ic_ar_valid_i),
    .dc_req     (dc_ar_valid_i),
    .win_accept (ar_fire_s),
    .win_grant  (grant_r),
    .pick       (pick_s)
  );

  assign ar_fire_s    = (state_r == S_AR) && m_ar_ready_i;
  assign r_done_s     = (state_r == S_R) && m_r_valid_i && m_r_ready_o && m_r_last_i;
  assign m_ar_valid_o = (state_r == S_AR);
  assign m_ar_addr_o  = addr_r;
  assign m_ar_len_o   = len_r;
  assign m_ar_id_o    = id_r;
  assign m_ar_size_o  = SIZE_8B;
  assign m_ar_burst_o = BURST_INCR;

  // Next state: arbitrate and latch the winner's AR in idle, r_last ends the burst
  always_comb begin
    state_s = state_r;
    grant_s = grant_r;
    addr_s  = addr_r;
    len_s   = len_r;
    id_s    = id_r;
    case (state_r)
      S_IDLE: begin
        if (ic_ar_valid_i || dc_ar_valid_i) begin
          state_s = S_AR;
          grant_s = pick_s;
          if (pick_s == GNT_DC) begin
            addr_s = dc_ar_addr_i;
            len_s  = dc_ar_len_i;
            id_s   = DC_ID_C;
          end else begin
            addr_s = ic_ar_addr_i;
            len_s  = ic_ar_len_i;
            id_s   = IC_ID_C;
          end
        end else begin
          state_s = S_IDLE;
        end
      end
      S_AR: begin
        if (ar_fire_s) begin
          state_s = S_R;
        end else begin
          state_s = S_AR;
        end
      end
      S_R: begin
        if (r_done_s) begin
          state_s = S_IDLE;
        end else begin
          state_s = S_R;
        end
      end
      default: state_s = S_IDLE;
    endcase
  end

  // State, grant and latched AR fields
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
      grant_r <= GNT_IC;
      addr_r  <= {ADDR_WIDTH{1'b0}};
      len_r   <= {LEN_WIDTH{1'b0}};
      id_r    <= {ID_WIDTH{1'b0}};
    end else begin
      state_r <= state_s;
      grant_r <= grant_s;
      addr_r  <= addr_s;
      len_r   <= len_s;
      id_r    <= id_s;
    end
  end

  // Route AR ready and the R channel to the granted requester only
  always_comb begin
    ic_ar_ready_o = 1'b0;
    dc_ar_ready_o = 1'b0;
    m_r_ready_o   = 1'b0;
    ic_r_valid_o  = 1'b0;
    ic_r_resp_o   = 2'b00;
    ic_r_last_o   = 1'b0;
    ic_r_data_o   = {DATA_WIDTH{1'b0}};
    dc_r_valid_o  = 1'b0;
    dc_r_resp_o   = 2'b00;
    dc_r_last_o   = 1'b0;
    dc_r_data_o   = {DATA_WIDTH{1'b0}};
    case (state_r)
      S_AR: begin
        if (grant_r == GNT_DC) begin
          dc_ar_ready_o = m_ar_ready_i;
        end else begin
          ic_ar_ready_o = m_ar_ready_i;
        end
      end
      S_R: begin
        if (grant_r == GNT_DC) begin
          m_r_ready_o  = dc_r_ready_i;
          dc_r_valid_o = m_r_valid_i;
          dc_r_resp_o  = m_r_resp_i;
          dc_r_last_o  = m_r_last_i;
          dc_r_data_o  = m_r_data_i;
        end else begin
          m_r_ready_o  = ic_r_ready_i;
          ic_r_valid_o = m_r_valid_i;
          ic_r_resp_o  = m_r_resp_i;
          ic_r_last_o  = m_r_last_i;
          ic_r_data_o  = m_r_data_i;
        end
      end
      default: m_r_ready_o = 1'b0;
    endcase
  end

endmodule
